// File: rtl/csr_rmw_sequencer_if.sv
// Handshake bundle between the Zicsr sequencer, the core pipeline and the CSR file.
// The master side is the sequencer; the slave side is the core plus the CSR file.
interface csr_rmw_sequencer_if #(
    parameter int XLEN = 32
);
    logic            iStart;
    logic [31:0]     iInstrucao;
    logic [XLEN-1:0] iRs1Data;
    logic [11:0]     oCsrAddr;
    logic            oCsrRdReq;
    logic            iCsrRdValid;
    logic [XLEN-1:0] iCsrRdData;
    logic            oCsrWrEn;
    logic [XLEN-1:0] oCsrWrData;
    logic            iCsrWrAck;
    logic            oBusy;
    logic            oRdWe;
    logic [4:0]      oRdAddr;
    logic [XLEN-1:0] oRdData;
    logic            oDone;
    logic            oIllegal;

    modport master (
        input  iStart, iInstrucao, iRs1Data, iCsrRdValid, iCsrRdData, iCsrWrAck,
        output oCsrAddr, oCsrRdReq, oCsrWrEn, oCsrWrData, oBusy,
               oRdWe, oRdAddr, oRdData, oDone, oIllegal
    );

    modport slave (
        output iStart, iInstrucao, iRs1Data, iCsrRdValid, iCsrRdData, iCsrWrAck,
        input  oCsrAddr, oCsrRdReq, oCsrWrEn, oCsrWrData, oBusy,
               oRdWe, oRdAddr, oRdData, oDone, oIllegal
    );
endinterface

// File: rtl/csr_rmw_sequencer.sv
// Multicycle Zicsr read-modify-write sequencer: decodes CSRRW/S/C(I), runs the
// READ/WRITE handshakes against the CSR file and returns the old value for rd.
module csr_rmw_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int XLEN    = 32
) (
    input logic                 iCLK,
    input logic                 iRST,
    csr_rmw_sequencer_if.master bus
);
    localparam int            CW   = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    // op encodes funct3[1:0]: 01 = RW, 10 = RS, 11 = RC
    function automatic logic [XLEN-1:0] modify(input logic [1:0]      op,
                                               input logic [XLEN-1:0] old,
                                               input logic [XLEN-1:0] operand);
        case (op)
            2'b01:   modify = operand;
            2'b10:   modify = old | operand;
            default: modify = old & ~operand;
        endcase
    endfunction

    state_t          state, state_nx;
    logic [11:0]     addr_q;
    logic [4:0]      rd_q;
    logic [1:0]      op_q;
    logic [XLEN-1:0] operand_q;
    logic [XLEN-1:0] old_q;
    logic            doread_q;
    logic            dowrite_q;
    logic            illegal_q;
    logic [CW-1:0]   cnt_q;

    logic [2:0]      dec_f3;
    logic [4:0]      dec_src;
    logic [4:0]      dec_rd;
    logic [11:0]     dec_addr;
    logic            dec_rw;
    logic            dec_doread;
    logic            dec_dowrite;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_operand;
    logic            unused_opcode;

    assign dec_f3      = bus.iInstrucao[14:12];
    assign dec_src     = bus.iInstrucao[19:15];
    assign dec_rd      = bus.iInstrucao[11:7];
    assign dec_addr    = bus.iInstrucao[31:20];
    assign dec_rw      = (dec_f3[1:0] == 2'b01);
    assign dec_operand = dec_f3[2] ? XLEN'(dec_src) : bus.iRs1Data;
    // RS/RC suppress the write on the rs1 index being x0, never on its value
    assign dec_doread  = !(dec_rw && (dec_rd == 5'd0));
    assign dec_dowrite = dec_rw || (dec_src != 5'd0);
    assign dec_illegal = (dec_f3[1:0] == 2'b00) || (dec_dowrite && (dec_addr[11:10] == 2'b11));
    assign unused_opcode = &{1'b0, bus.iInstrucao[6:0]};

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state     <= IDLE;
            addr_q    <= '0;
            rd_q      <= '0;
            op_q      <= '0;
            operand_q <= '0;
            old_q     <= '0;
            doread_q  <= 1'b0;
            dowrite_q <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (bus.iStart) begin
                        addr_q    <= dec_addr;
                        rd_q      <= dec_rd;
                        op_q      <= dec_f3[1:0];
                        operand_q <= dec_operand;
                        old_q     <= '0;
                        doread_q  <= dec_doread;
                        dowrite_q <= dec_dowrite;
                        illegal_q <= dec_illegal;
                        cnt_q     <= '0;
                    end
                end
                READ: begin
                    if (bus.iCsrRdValid) begin
                        old_q <= bus.iCsrRdData;
                        cnt_q <= '0;
                    end else if (cnt_q == LAST) begin
                        illegal_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    if (!bus.iCsrWrAck) begin
                        if (cnt_q == LAST) illegal_q <= 1'b1;
                        else               cnt_q     <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.iStart) begin
                    if (dec_illegal)      state_nx = RESP;
                    else if (dec_doread)  state_nx = READ;
                    else if (dec_dowrite) state_nx = WRITE;
                    else                  state_nx = RESP;
                end
            end
            READ: begin
                if (bus.iCsrRdValid)  state_nx = dowrite_q ? WRITE : RESP;
                else if (cnt_q == LAST) state_nx = RESP;
            end
            WRITE: begin
                if (bus.iCsrWrAck || (cnt_q == LAST)) state_nx = RESP;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign bus.oBusy      = (state != IDLE);
    assign bus.oCsrAddr   = addr_q;
    assign bus.oCsrRdReq  = (state == READ);
    assign bus.oCsrWrEn   = (state == WRITE);
    assign bus.oCsrWrData = (state == WRITE) ? modify(op_q, old_q, operand_q) : '0;
    assign bus.oDone      = (state == RESP);
    assign bus.oIllegal   = (state == RESP) && illegal_q;
    assign bus.oRdWe      = (state == RESP) && doread_q && !illegal_q;
    assign bus.oRdAddr    = rd_q;
    assign bus.oRdData    = old_q;
endmodule

// File: tb/tb_csr_rmw_sequencer.sv
// Self-checking bench for csr_rmw_sequencer: directed Zicsr cases, timeouts,
// mid-sequence reset and randomized traffic against a transaction-level model.
module tb_csr_rmw_sequencer;
    localparam int TIMEOUT = 16;
    localparam int XLEN    = 32;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    csr_rmw_sequencer_if #(.XLEN(XLEN)) bus ();

    csr_rmw_sequencer #(.TIMEOUT(TIMEOUT), .XLEN(XLEN)) dut (
        .iCLK (clk),
        .iRST (rst),
        .bus  (bus)
    );

    function automatic logic [31:0] mk(input logic [11:0] csr, input logic [4:0] src,
                                       input logic [2:0] f3, input logic [4:0] rd);
        return {csr, src, f3, rd, 7'b1110011};
    endfunction

    function automatic logic outs_zero();
        return ({bus.oCsrAddr, bus.oCsrRdReq, bus.oCsrWrEn, bus.oCsrWrData, bus.oBusy,
                 bus.oRdWe, bus.oRdAddr, bus.oRdData, bus.oDone, bus.oIllegal} === '0);
    endfunction

    task automatic idle_inputs();
        bus.iStart      = 1'b0;
        bus.iInstrucao  = '0;
        bus.iRs1Data    = '0;
        bus.iCsrRdValid = 1'b0;
        bus.iCsrRdData  = '0;
        bus.iCsrWrAck   = 1'b0;
    endtask

    // One instruction end to end; the bench plays the CSR file with the given
    // wait states (>= TIMEOUT means the handshake never arrives).
    task automatic run_txn(input logic [31:0] instr, input logic [31:0] rs1,
                           input logic [31:0] old, input int rd_dly, input int wr_dly,
                           input string name);
        logic [2:0]  f3;
        logic [1:0]  op;
        logic [4:0]  src, rd;
        logic [11:0] csr;
        logic [31:0] operand, seen, e_wdata, wdata, g_rddata;
        logic        e_rd, e_wr, e_ill, e_rdwe;
        int          e_rdcyc, e_wrcyc, e_done, c;
        int          cyc, rdcyc, wrcyc, overlap, addr_err, unstable, done_cyc;
        logic        done_seen, g_ill, g_rdwe, vld, ack, rdreq, wren;
        logic [4:0]  g_rdaddr;

        f3 = instr[14:12]; op = f3[1:0]; src = instr[19:15]; rd = instr[11:7]; csr = instr[31:20];
        operand = f3[2] ? {27'd0, src} : rs1;
        e_rd  = !((op == 2'b01) && (rd == 5'd0));
        e_wr  = (op == 2'b01) || (src != 5'd0);
        e_ill = (op == 2'b00) || (e_wr && (csr[11:10] == 2'b11));
        e_rdcyc = 0; e_wrcyc = 0; e_wdata = '0; e_done = 2; seen = '0;
        if (!e_ill) begin
            c = 1;
            if (e_rd) begin
                if (rd_dly >= TIMEOUT) begin e_rdcyc = TIMEOUT; c += TIMEOUT; e_ill = 1'b1; end
                else begin e_rdcyc = rd_dly + 1; c += rd_dly + 1; seen = old; end
            end
            if (e_wr && !e_ill) begin
                e_wdata = (op == 2'b01) ? operand : (op == 2'b10) ? (seen | operand) : (seen & ~operand);
                if (wr_dly >= TIMEOUT) begin e_wrcyc = TIMEOUT; c += TIMEOUT; e_ill = 1'b1; end
                else begin e_wrcyc = wr_dly + 1; c += wr_dly + 1; end
            end
            e_done = c + 1;
        end
        e_rdwe = e_rd && !e_ill;

        @(negedge clk);
        total++;
        if (bus.oBusy !== 1'b0) begin
            bad++; $display("FAIL %s idle_before_start: busy=%b want 0", name, bus.oBusy);
        end
        bus.iStart = 1'b1; bus.iInstrucao = instr; bus.iRs1Data = rs1;
        cyc = 1; rdcyc = 0; wrcyc = 0; overlap = 0; addr_err = 0; unstable = 0;
        done_cyc = 0; done_seen = 1'b0; wdata = '0; g_ill = 1'b0; g_rdwe = 1'b0;
        g_rdaddr = '0; g_rddata = '0;
        for (int k = 0; k < 60 && !done_seen; k++) begin
            @(negedge clk);
            cyc++;
            rdreq = bus.oCsrRdReq; wren = bus.oCsrWrEn;
            vld = 1'b0; ack = 1'b0;
            if (rdreq && wren) overlap++;
            if ((rdreq || wren) && (bus.oCsrAddr !== csr)) addr_err++;
            if (rdreq) begin rdcyc++; vld = (rdcyc > rd_dly); end
            if (wren) begin
                wrcyc++;
                if (wrcyc == 1) wdata = bus.oCsrWrData;
                else if (bus.oCsrWrData !== wdata) unstable++;
                ack = (wrcyc > wr_dly);
            end
            if (bus.oDone === 1'b1) begin
                done_seen = 1'b1; done_cyc = cyc; g_ill = bus.oIllegal; g_rdwe = bus.oRdWe;
                g_rdaddr = bus.oRdAddr; g_rddata = bus.oRdData;
            end
            // noise: new starts while busy and stray handshakes must be ignored
            bus.iStart      = 1'($urandom_range(0, 1));
            bus.iInstrucao  = $urandom;
            bus.iRs1Data    = $urandom;
            bus.iCsrRdValid = rdreq ? vld : 1'($urandom_range(0, 1));
            bus.iCsrRdData  = (rdreq && vld) ? old : $urandom;
            bus.iCsrWrAck   = wren ? ack : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        total++;
        if (bus.oDone !== 1'b0 || bus.oBusy !== 1'b0) begin
            bad++; $display("FAIL %s done_single_pulse: done=%b busy=%b want 0 0", name, bus.oDone, bus.oBusy);
        end
        idle_inputs();

        total++;
        if (!done_seen) begin
            bad++; $display("FAIL %s done_timeout: no oDone within budget", name);
        end
        total++;
        if (done_cyc != e_done) begin
            bad++; $display("FAIL %s done_cycle: got %0d want %0d", name, done_cyc, e_done);
        end
        total++;
        if (g_ill !== e_ill) begin
            bad++; $display("FAIL %s illegal: got %b want %b", name, g_ill, e_ill);
        end
        total++;
        if (g_rdwe !== e_rdwe) begin
            bad++; $display("FAIL %s rd_we: got %b want %b", name, g_rdwe, e_rdwe);
        end
        total++;
        if (rdcyc != e_rdcyc) begin
            bad++; $display("FAIL %s rdreq_cycles: got %0d want %0d", name, rdcyc, e_rdcyc);
        end
        total++;
        if (wrcyc != e_wrcyc) begin
            bad++; $display("FAIL %s wren_cycles: got %0d want %0d", name, wrcyc, e_wrcyc);
        end
        if (e_wrcyc > 0) begin
            total++;
            if (wdata !== e_wdata) begin
                bad++; $display("FAIL %s wr_data: got %h want %h", name, wdata, e_wdata);
            end
        end
        if (e_rdwe) begin
            total++;
            if (g_rdaddr !== rd || g_rddata !== old) begin
                bad++; $display("FAIL %s rd_result: got x%0d=%h want x%0d=%h", name, g_rdaddr, g_rddata, rd, old);
            end
        end
        total++;
        if (overlap != 0 || addr_err != 0 || unstable != 0) begin
            bad++; $display("FAIL %s bus_rules: overlap=%0d addr_err=%0d unstable=%0d want 0 0 0",
                            name, overlap, addr_err, unstable);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        bus.iStart = 1'b1;
        bus.iInstrucao = mk(12'h340, 5'd6, 3'b001, 5'd5);
        repeat (2) @(negedge clk);
        total++;
        if (!outs_zero()) begin
            bad++; $display("FAIL reset_outputs: busy=%b done=%b addr=%h want all 0", bus.oBusy, bus.oDone, bus.oCsrAddr);
        end
        bus.iStart = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (!outs_zero()) begin
            bad++; $display("FAIL reset_release_idle: busy=%b done=%b want 0 0", bus.oBusy, bus.oDone);
        end
    endtask

    task automatic test_directed();
        run_txn(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEADBEEF, 32'h12345678, 0, 0, "csrrw_x5");
        run_txn(mk(12'h300, 5'd0, 3'b010, 5'd0), 32'hFFFF0000, 32'hCAFE0001, 0, 0, "csrrs_x0_x0");
        run_txn(mk(12'h300, 5'd8, 3'b110, 5'd1), 32'h0, 32'h00000001, 0, 0, "csrrsi_8");
        run_txn(mk(12'h300, 5'h1F, 3'b111, 5'd2), 32'h0, 32'hFFFFFFFF, 0, 0, "csrrci_1f");
        run_txn(mk(12'hC00, 5'd3, 3'b001, 5'd1), 32'h55AA55AA, 32'h1, 0, 0, "csrrw_ro_addr");
        run_txn(mk(12'h300, 5'd3, 3'b100, 5'd1), 32'h55AA55AA, 32'h1, 0, 0, "funct3_100");
        run_txn(mk(12'h305, 5'd7, 3'b000, 5'd4), 32'h1, 32'h1, 0, 0, "funct3_000");
        run_txn(mk(12'h305, 5'd7, 3'b001, 5'd0), 32'h80000000, 32'h7, 0, 0, "csrrw_rd0_write_only");
        run_txn(mk(12'hC01, 5'd0, 3'b010, 5'd9), 32'hFFFFFFFF, 32'hABCD0123, 0, 0, "csrrs_ro_read_only");
        run_txn(mk(12'h341, 5'd12, 3'b011, 5'd3), 32'h0F0F0F0F, 32'hFFFF00FF, 2, 3, "csrrc_waits");
        run_txn(mk(12'h341, 5'd12, 3'b011, 5'd3), 32'h0, 32'hFFFF00FF, 1, 0, "csrrc_zero_value");
        run_txn(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'h1234, 32'h5678, TIMEOUT - 1, TIMEOUT - 1, "last_cycle_handshake");
    endtask

    task automatic test_timeout();
        run_txn(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEADBEEF, 32'h12345678, 100, 0, "read_timeout");
        run_txn(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEADBEEF, 32'h12345678, 0, 100, "write_timeout");
        run_txn(mk(12'h340, 5'd6, 3'b001, 5'd0), 32'hDEADBEEF, 32'h0, 0, 100, "write_only_timeout");
    endtask

    task automatic test_reset_mid();
        int wcyc;
        int dones;
        @(negedge clk);
        bus.iStart = 1'b1;
        bus.iInstrucao = mk(12'h340, 5'd6, 3'b001, 5'd5);
        bus.iRs1Data = 32'hDEADBEEF;
        wcyc = 0;
        for (int k = 0; k < 20 && wcyc < 2; k++) begin
            @(negedge clk);
            bus.iStart      = bus.oBusy ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.iCsrRdValid = bus.oCsrRdReq;
            bus.iCsrRdData  = 32'h12345678;
            bus.iCsrWrAck   = 1'b0;
            if (bus.oCsrWrEn) wcyc++;
        end
        total++;
        if (wcyc != 2) begin
            bad++; $display("FAIL reset_mid_reach_write: write cycles=%0d want 2", wcyc);
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (!outs_zero()) begin
            bad++; $display("FAIL reset_mid_async: busy=%b wren=%b done=%b want 0 0 0", bus.oBusy, bus.oCsrWrEn, bus.oDone);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.oDone || bus.oBusy) dones++;
            bus.iCsrWrAck = 1'b1;
        end
        bus.iCsrWrAck = 1'b0;
        total++;
        if (dones != 0) begin
            bad++; $display("FAIL reset_mid_no_done: done/busy cycles=%0d want 0", dones);
        end
        run_txn(mk(12'h340, 5'd6, 3'b001, 5'd5), 32'hDEADBEEF, 32'h12345678, 0, 3, "after_reset");
    endtask

    task automatic test_random();
        logic [11:0] csr;
        logic [4:0]  src, rd;
        int          rdl, wrl, r;
        for (int i = 0; i < 150; i++) begin
            csr = 12'($urandom);
            src = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            r   = $urandom_range(0, 9);
            rdl = (r == 9) ? 20 : r % 4;
            r   = $urandom_range(0, 9);
            wrl = (r == 9) ? 20 : r % 4;
            run_txn(mk(csr, src, 3'($urandom_range(0, 7)), rd), $urandom, $urandom, rdl, wrl,
                    $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
